// File: rtl/timer_irq_pkg.sv
// ---------------------------------------------------------------------------
// timer_irq_pkg
// Shared definitions for the timer interrupt controller: register window
// base and offsets, missed-expiry counter width, FSM state encoding and a
// small address-decode helper.
// ---------------------------------------------------------------------------
package timer_irq_pkg;

    // Byte address of the three-word register window
    localparam logic [31:0] IRQ_BASE   = 32'h8008_0010;

    localparam logic [31:0] CTRL_OFS   = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;
    localparam logic [31:0] COUNT_OFS  = 32'd8;

    // Width of the saturating missed-expiry counter
    localparam int COUNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } irq_state_e;

    // Exact word match; byte lanes are not decoded
    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] ofs);
        return addr == (IRQ_BASE + ofs);
    endfunction

endpackage

// File: rtl/zero_edge_detect.sv
// ---------------------------------------------------------------------------
// zero_edge_detect
// Watches the live count of the countdown timer and emits a one-cycle
// expiry strobe on the nonzero-to-zero transition. The strobe is
// combinational from the current value and the registered "was nonzero"
// flag, so it is valid in the same cycle the zero appears.
// The flag resets to 0: a timer already sitting at 0 out of reset
// produces no expiry.
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous reset, active low
//   value   in   current timer count, synchronous to clk
//   expiry  out  one-cycle strobe, value==0 while previous value was nonzero
// ---------------------------------------------------------------------------
module zero_edge_detect #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] value,
    output logic         expiry
);

    logic prev_nz_q;
    logic prev_nz_d;

    always_comb begin
        prev_nz_d = (value != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_nz_q <= 1'b0;
        end else begin
            prev_nz_q <= prev_nz_d;
        end
    end

    assign expiry = prev_nz_q & ~prev_nz_d;

endmodule

// File: rtl/timer_irq_ctrl.sv
// ---------------------------------------------------------------------------
// timer_irq_ctrl
// Interrupt controller downstream of the millisecond countdown timer.
// Latches a pending flag on timer expiry and raises a registered level
// interrupt while enabled, until software clears it with a write-1-to-clear
// to STATUS. Shares the timer's 32-bit tri-state bus.
//
// Register window (IRQ_BASE = 32'h8008_0010):
//   +0 CTRL    bit0 enable, R/W
//   +4 STATUS  bit0 pending, read / write-1-to-clear
//   +8 COUNT   saturating count of expiries seen while already pending;
//              built only when TIMER_IRQ_COUNT_EN is defined, else reads 0
//
// Build option:
//   TIMER_IRQ_COUNT_EN  - include the missed-expiry counter
//
// Ports:
//   clk          in     system clock
//   rst          in     asynchronous reset, active low
//   wren         in     bus write enable
//   rd           in     bus read enable
//   address      in     bus byte address
//   data         inout  shared bus, driven only on a read hit
//   timer_value  in     live count from the countdown timer
//   irq          out    registered level interrupt request
// ---------------------------------------------------------------------------
module timer_irq_ctrl
    import timer_irq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wren,
    input  logic        rd,
    input  logic [31:0] address,
    inout  wire  [31:0] data,
    input  logic [31:0] timer_value,
    output logic        irq
);

    // -----------------------------------------------------------------
    // Expiry detection
    // -----------------------------------------------------------------
    logic expiry;

    zero_edge_detect #(
        .W (32)
    ) u_zero_edge_detect (
        .clk    (clk),
        .rst    (rst),
        .value  (timer_value),
        .expiry (expiry)
    );

    // -----------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------
    logic hit_ctrl;
    logic hit_status;
    logic hit_count;
    logic wr_ctrl;
    logic wr_status_clr;

    always_comb begin
        hit_ctrl      = addr_hit(address, CTRL_OFS);
        hit_status    = addr_hit(address, STATUS_OFS);
        hit_count     = addr_hit(address, COUNT_OFS);
        wr_ctrl       = wren & hit_ctrl;
        wr_status_clr = wren & hit_status & data[0];
    end

    // Only bit 0 of write data carries meaning
    logic unused_wdata;
    assign unused_wdata = ^data[31:1];

    // -----------------------------------------------------------------
    // Register file: enable and pending
    // -----------------------------------------------------------------
    logic enable_q;
    logic enable_d;
    logic pending_q;
    logic pending_d;

    always_comb begin
        enable_d = enable_q;
        if (wr_ctrl) begin
            enable_d = data[0];
        end

        // Expiry takes priority over a simultaneous clear
        pending_d = pending_q;
        if (expiry) begin
            pending_d = 1'b1;
        end else if (wr_status_clr) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            enable_q  <= enable_d;
            pending_q <= pending_d;
        end
    end

    // -----------------------------------------------------------------
    // Missed-expiry counter
    // -----------------------------------------------------------------
    logic [31:0] count_rd;

`ifdef TIMER_IRQ_COUNT_EN
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               wr_count;

    always_comb begin
        wr_count = wren & hit_count;
        count_d  = count_q;
        // A write always wins, even against a coincident expiry
        if (wr_count) begin
            count_d = '0;
        end else if (expiry && pending_q && (count_q != {COUNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_rd = {{(32-COUNT_W){1'b0}}, count_q};
`else
    assign count_rd = 32'h0;
`endif

    // -----------------------------------------------------------------
    // Interrupt FSM
    // State follows (enable, pending) one edge later; irq is the FIRED
    // decode of the next state, registered so it is glitch free and
    // clears asynchronously with reset.
    // -----------------------------------------------------------------
    irq_state_e state_q;
    irq_state_e state_d;
    logic       irq_q;
    logic       irq_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // Re-enabling with a flag still pending fires at once
                if (enable_q && pending_q) begin
                    state_d = FIRED;
                end else if (enable_q) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!enable_q) begin
                    state_d = IDLE;
                end else if (pending_q) begin
                    state_d = FIRED;
                end
            end
            FIRED: begin
                if (!enable_q) begin
                    state_d = IDLE;
                end else if (!pending_q) begin
                    state_d = ARMED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        irq_d = (state_d == FIRED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
        end
    end

    assign irq = irq_q;

    // -----------------------------------------------------------------
    // Bus read driver: combinational from registered state
    // -----------------------------------------------------------------
    logic        rd_drive;
    logic [31:0] rd_data;

    always_comb begin
        rd_drive = rd & ~wren & (hit_ctrl | hit_status | hit_count);
        rd_data  = 32'h0;
        if (hit_ctrl) begin
            rd_data[0] = enable_q;
        end else if (hit_status) begin
            rd_data[0] = pending_q;
        end else if (hit_count) begin
            rd_data = count_rd;
        end
    end

    assign data = rd_drive ? rd_data : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_irq_ctrl
// Directed scenarios followed by randomized bus/timer traffic, checked
// against a cycle-level behavioural model of the register window.
// When the DUT must leave the bus floating, the bench drives a keeper
// pattern and expects to read exactly that pattern back.
// ---------------------------------------------------------------------------
module tb_timer_irq_ctrl;

    localparam logic [31:0] BASE = 32'h8008_0010;
    localparam logic [31:0] KEEP = 32'hA5C3_5A3C;
`ifdef TIMER_IRQ_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wren;
    logic        rd;
    logic [31:0] address;
    logic [31:0] timer_value;
    logic        irq;
    wire  [31:0] data;

    logic        tb_drv_en;
    logic [31:0] tb_drv_val;
    assign data = tb_drv_en ? tb_drv_val : 32'hzzzz_zzzz;

    always #10 clk = ~clk;

    timer_irq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .wren        (wren),
        .rd          (rd),
        .address     (address),
        .data        (data),
        .timer_value (timer_value),
        .irq         (irq)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model
    bit m_en;
    bit m_pend;
    bit m_was_nz;
    bit m_irq;
    int m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_pend = 0; m_was_nz = 0; m_irq = 0; m_cnt = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a == BASE)     return {31'h0, m_en};
        if (a == BASE + 4) return {31'h0, m_pend};
        if (a == BASE + 8) return CNT_EN ? m_cnt : 32'h0;
        return KEEP;
    endfunction

    // One clock of traffic. Called just after a falling edge; the read
    // value is checked before the rising edge, irq after it.
    task automatic bus_cycle(input logic w, input logic r, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] tv,
                             input string tag);
        bit mapped, dut_drives, expired, new_irq;
        wren = w; rd = r; address = a; timer_value = tv;
        mapped     = (a == BASE) || (a == BASE + 4) || (a == BASE + 8);
        dut_drives = r && !w && mapped;
        tb_drv_en  = !dut_drives;
        tb_drv_val = w ? wd : KEEP;
        #1;
        if (dut_drives) check_eq({tag, "_rd"}, data, model_read(a));
        else            check_eq({tag, "_float"}, data, tb_drv_val);
        if (w || r)
            $display("txn %-10s wr=%0b rd=%0b addr=%h wd=%h tv=%0d data=%h",
                     tag, w, r, a, wd, tv, data);
        @(posedge clk);
        // Interrupt follows enable && pending one edge later
        new_irq = m_en && m_pend;
        expired = (tv == 0) && m_was_nz;
        if (w && a == BASE + 8)
            m_cnt = 0;
        else if (expired && m_pend && m_cnt < 255)
            m_cnt = m_cnt + 1;
        if (expired)                         m_pend = 1;
        else if (w && a == BASE + 4 && wd[0]) m_pend = 0;
        if (w && a == BASE) m_en = wd[0];
        m_was_nz = (tv != 0);
        m_irq    = new_irq;
        @(negedge clk);
        check_eq({tag, "_irq"}, {31'h0, irq}, {31'h0, m_irq});
    endtask

    task automatic idle(input logic [31:0] tv);
        bus_cycle(1'b0, 1'b0, BASE, 32'h0, tv, "idle");
    endtask

    initial begin
        rst = 1'b0; wren = 0; rd = 0; address = 0; timer_value = 0;
        tb_drv_en = 1'b1; tb_drv_val = KEEP;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_irq", {31'h0, irq}, 32'h0);
        rst = 1'b1;

        // Reset with timer at 0: no expiry may appear
        repeat (10) idle(32'h0);
        check_eq("hold_irq", {31'h0, irq}, 32'h0);
        bus_cycle(0, 1, BASE + 4, 0, 0, "rd_status");
        bus_cycle(0, 1, BASE,     0, 0, "rd_ctrl");
        bus_cycle(0, 1, BASE + 8, 0, 0, "rd_count");
        bus_cycle(0, 1, BASE + 12, 0, 0, "rd_unmap");

        // Enable then count down 3-2-1-0
        bus_cycle(1, 0, BASE, 32'h1, 3, "wr_ctrl");
        idle(2); idle(1);
        idle(0);
        check_eq("lat_edge1", {31'h0, irq}, 32'h0);
        bus_cycle(0, 1, BASE + 4, 0, 0, "rd_pend");
        check_eq("lat_edge2", {31'h0, irq}, 32'h1);

        // W1C with 0 does nothing, with 1 clears
        bus_cycle(1, 0, BASE + 4, 32'h0, 0, "w0c");
        check_eq("w0c_irq", {31'h0, irq}, 32'h1);
        bus_cycle(1, 0, BASE + 4, 32'h1, 0, "w1c");
        check_eq("w1c_edge1", {31'h0, irq}, 32'h1);
        bus_cycle(0, 1, BASE + 4, 0, 0, "rd_clr");
        check_eq("w1c_edge2", {31'h0, irq}, 32'h0);

        // Re-fire, then expiry coincident with W1C
        idle(1); idle(0); idle(0); idle(1);
        bus_cycle(1, 0, BASE + 4, 32'h1, 0, "w1c_exp");
        bus_cycle(0, 1, BASE + 4, 0, 0, "rd_exp_win");
        check_eq("exp_win_irq", {31'h0, irq}, 32'h1);

        // Disable while pending keeps the flag; re-enable fires directly
        bus_cycle(1, 0, BASE, 32'h0, 0, "dis");
        idle(0);
        check_eq("dis_irq", {31'h0, irq}, 32'h0);
        bus_cycle(0, 1, BASE + 4, 0, 0, "rd_kept");
        bus_cycle(1, 0, BASE, 32'h1, 0, "reen");
        idle(0);
        check_eq("reen_irq", {31'h0, irq}, 32'h1);

        // 300 expiries while pending saturate COUNT
        for (int i = 0; i < 300; i++) begin
            idle(1); idle(0);
        end
        bus_cycle(0, 1, BASE + 8, 0, 0, "rd_sat");
        bus_cycle(1, 0, BASE + 8, 32'hFFFF_FFFF, 0, "wr_count");
        bus_cycle(0, 1, BASE + 8, 0, 0, "rd_cnt0");

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [31:0] tv, a, wd;
            int sel;
            case ($urandom_range(0, 3))
                0: tv = 0;
                1: tv = 1;
                2: tv = $urandom_range(2, 5);
                default: tv = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: a = BASE;
                1: a = BASE + 4;
                2: a = BASE + 8;
                3: a = BASE + 12;
                4: a = BASE + 2;
                default: a = BASE - 4;
            endcase
            wd  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 3)      bus_cycle(1, 0, a, wd, tv, "rnd_wr");
            else if (sel < 6) bus_cycle(0, 1, a, 0, tv, "rnd_rd");
            else if (sel < 7) bus_cycle(1, 1, a, wd, tv, "rnd_wrrd");
            else              bus_cycle(0, 0, a, 0, tv, "rnd_idle");
        end

        // Asynchronous reset in the middle of FIRED
        bus_cycle(1, 0, BASE, 32'h1, 1, "wr_ctrl2");
        idle(0); idle(0); idle(0);
        check_eq("pre_rst_irq", {31'h0, irq}, 32'h1);
        #3;
        rst = 1'b0;
        #1;
        check_eq("async_rst_irq", {31'h0, irq}, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus_cycle(0, 1, BASE,     0, 0, "post_ctrl");
        bus_cycle(0, 1, BASE + 4, 0, 0, "post_status");
        bus_cycle(0, 1, BASE + 8, 0, 0, "post_count");
        idle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_irq_ctrl.md
# timer_irq_ctrl

Memory-mapped interrupt controller sitting directly downstream of the millisecond countdown timer. It watches the timer's live count, detects the nonzero-to-zero transition (expiry), latches a pending flag and raises a level interrupt to the ZPU core until software clears it over the shared 32-bit tri-state bus. It shares the same address/data/wren/rd bus as the timer and occupies its own small register window.

## Interface
- IRQ_BASE, 32'h80080010: byte address of register window; three words at +0, +4, +8.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-low.
- wren  in  1  bus write enable.
- rd  in  1  bus read enable.
- address  in  32  bus byte address.
- data  inout  32  shared bus; driven only on a read hit, otherwise Z.
- timer_value  in  32  current count from the countdown timer, synchronous to clk.
- irq  out  1  level interrupt request to the CPU, registered.

## Operation
- Registers:
  - CTRL at IRQ_BASE+0: bit0 = enable. R/W. Other bits read 0.
  - STATUS at +4: bit0 = pending. Read returns pending. Write 1 to bit0 clears it; write 0 has no effect.
  - COUNT at +8: missed-expiry counter. Only exists with the macro; otherwise reads 0.
- Expiry detect: prev_nz is timer_value!=0 registered each cycle. An expiry is timer_value==0 && prev_nz==1.
- A write that loads the timer with 0 while it was nonzero also counts as an expiry. This is intended.
- FSM, 2-bit state:
  - IDLE: enable=0. Expiries are still latched into pending; irq=0.
  - ARMED: enable=1, pending=0. Expiry goes to FIRED.
  - FIRED: pending=1, irq=1. W1C on STATUS goes to ARMED. Clearing enable goes to IDLE, and pending is kept.
  - Setting enable while pending=1 goes directly to FIRED.
- Simultaneous events:
  - Expiry and STATUS W1C in the same cycle: expiry wins and pending stays 1.
  - Expiry while already pending: pending stays 1 and COUNT increments when the macro is compiled in.
- Bus:
  - Write hit requires wren && exact word address.
  - Read drives data when rd && ~wren && address is one of the three words. Otherwise data=Z, including unmapped addresses.
  - Byte lanes are ignored; all accesses are full word.

## Timing
- Reset values: CTRL=0, pending=0, prev_nz=0, COUNT=0, state=IDLE, irq=0, data=Z.
- Because prev_nz resets to 0, a timer already at 0 out of reset produces no expiry.
- timer_value reaches 0 in cycle N:
  - pending=1 after the edge ending cycle N.
  - irq=1 after the following edge.
  - Total latency is 2 clocks.
- STATUS W1C in cycle M drops pending at the edge ending M; irq drops one edge later.
- CTRL write takes effect at the edge ending the write cycle. irq follows one edge later.
- Reads are combinational from registered state with zero wait states. A read in the same cycle as an update returns the old value.
- Reset asserted mid-operation clears everything immediately, independent of clk. irq deasserts without waiting for an edge.

## Configuration
- Macro: TIMER_IRQ_COUNT_EN.
- Defined:
  - COUNT is an 8-bit saturating counter of expiries that occur while pending=1. It sticks at 255.
  - Any write to COUNT clears it to 0. The write data is ignored.
  - COUNT reads zero-extended to 32 bits.
  - An expiry coinciding with a COUNT write leaves the counter at 0.
- Not defined: no counter flops are built, and COUNT reads 32'h0. Writes to COUNT are ignored.

## Structure
- Package timer_irq_pkg:
  - Register offsets: CTRL_OFS=0, STATUS_OFS=4, COUNT_OFS=8.
  - COUNT_W=8.
  - The FSM state enum {IDLE, ARMED, FIRED}.
- One sub-module, zero_edge_detect: registers prev_nz and outputs a one-cycle expiry strobe.
- The top level holds the FSM, the register file and the bus driver.

## Test plan
- Reset with timer_value=0, hold 10 cycles → irq=0, STATUS reads 0, data=Z when idle.
- Write CTRL=1, drive timer_value 3→2→1→0 one per cycle → pending=1 one edge after 0 appears, irq=1 one edge after that. STATUS reads 1.
- From the fired state, write STATUS=1 → pending=0 at next edge, irq=0 one edge later. Write STATUS=0 on a pending flag → no change.
- Expiry and STATUS W1C in the same cycle → STATUS still reads 1 and irq stays 1.
- With TIMER_IRQ_COUNT_EN, cause 300 expiries (timer_value toggling 1/0) while pending=1 → COUNT reads 255. Write COUNT → reads 0.
- Assert rst mid-FIRED, between clock edges → irq=0 immediately. After release, CTRL, STATUS and COUNT read 0.
